dram_addr_mux_ctl: RTL and testbench

Parametrised DRAM row/column address multiplexer and strobe sequencer for the Nascom RAM board model. It generalises the quad 2-input mux pair that selected row or column address into a sequenced controller. It accepts a CPU-side access request, drives the multiplexed address with RAS/CAS/WE strobes, and captures read data. It also runs RAS-only refresh with a wrapping row counter, and sits between the bus decode logic and the DRAM array models.

---
 rtl/dram_addr_mux_ctl_if.sv | 22 ++
 rtl/dram_addr_mux_ctl.sv | 98 +++++++++
 tb/tb_dram_addr_mux_ctl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dram_addr_mux_ctl_if.sv
// dram_addr_mux_ctl_if: CPU request/response and DRAM strobe bundle for the address mux controller
interface dram_addr_mux_ctl_if #(
  parameter int ROW_W  = 7,
  parameter int DATA_W = 8
);
  logic                  req;
  logic [2*ROW_W-1:0]    addr;
  logic                  we;
  logic                  ack;
  logic [DATA_W-1:0]     rdata;
  logic                  busy;
  logic [ROW_W-1:0]      ma;
  logic                  ras_n;
  logic                  cas_n;
  logic                  we_n;
  logic [DATA_W-1:0]     dram_q;
  logic                  ref_overrun;
  modport master (output req, addr, we, dram_q,
                  input  ack, rdata, busy, ma, ras_n, cas_n, we_n, ref_overrun);
  modport slave  (input  req, addr, we, dram_q,
                  output ack, rdata, busy, ma, ras_n, cas_n, we_n, ref_overrun);
endinterface

// File: rtl/dram_addr_mux_ctl.sv
// dram_addr_mux_ctl: DRAM row/column mux and RAS/CAS sequencer; RAS-only refresh built when DRAM_REFRESH_EN is defined
module dram_addr_mux_ctl #(
  parameter int ROW_W      = 7,
  parameter int DATA_W     = 8,
  parameter int CAS_CYCLES = 2,
  parameter int PRE_CYCLES = 2,
  parameter int REF_PERIOD = 64
) (
  input logic               clk,
  input logic               rst,
  dram_addr_mux_ctl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ROW, COL, CAS, PRE, REF, RPRE} state_t;
  localparam int CW = $clog2(CAS_CYCLES + PRE_CYCLES + 2);
  if (CAS_CYCLES < 1 || PRE_CYCLES < 1 || REF_PERIOD < 2) begin : g_bad_params
    $error("dram_addr_mux_ctl: CAS_CYCLES/PRE_CYCLES must be >= 1 and REF_PERIOD >= 2");
  end
  state_t           state, nxt;
  logic [CW-1:0]    cnt, dur;
  logic             last;
  logic [ROW_W-1:0] row_l, col_l, ref_row;
  logic             we_l, ref_pend;
  // cnt restarts on every state change, so it measures time spent in the current state
  always_comb begin
    dur  = state == CAS ? CW'(CAS_CYCLES) :
           (state == PRE || state == RPRE) ? CW'(PRE_CYCLES) :
           state == REF ? CW'(CAS_CYCLES + 1) : CW'(1);
    last = cnt == dur - CW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      row_l     <= '0;
      col_l     <= '0;
      we_l      <= 1'b0;
      bus.rdata <= '0;
    end else begin
      state <= nxt;
      cnt   <= nxt != state ? '0 : cnt + 1'b1;
      if (state == IDLE && nxt == ROW) begin
        row_l <= bus.addr[2*ROW_W-1:ROW_W];
        col_l <= bus.addr[ROW_W-1:0];
        we_l  <= bus.we;
      end
      if (state == CAS && last && !we_l) bus.rdata <= bus.dram_q;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = ref_pend ? REF : bus.req ? ROW : IDLE;
      ROW:     nxt = COL;
      COL:     nxt = CAS;
      CAS:     nxt = last ? PRE : CAS;
      PRE:     nxt = last ? IDLE : PRE;
      REF:     nxt = last ? RPRE : REF;
      RPRE:    nxt = last ? IDLE : RPRE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.busy  = state != IDLE;
    bus.ras_n = !(state inside {ROW, COL, CAS, REF});
    bus.cas_n = state != CAS;
    bus.we_n  = (state == COL || state == CAS) ? ~we_l : 1'b1;
    bus.ma    = state == ROW ? row_l :
                (state == COL || state == CAS) ? col_l :
                state == REF ? ref_row : '0;
    bus.ack   = state == PRE && cnt == '0;
  end
`ifdef DRAM_REFRESH_EN
  localparam int TW = REF_PERIOD > 2 ? $clog2(REF_PERIOD) : 1;
  logic [TW-1:0] timer;
  logic          wrap, take, overrun;
  assign wrap = timer == TW'(REF_PERIOD - 1);
  assign take = state == IDLE && ref_pend;
  // a wrap that lands while a request is still waiting (and not being taken) loses one refresh
  always_ff @(posedge clk) begin
    if (rst) begin
      timer    <= '0;
      ref_pend <= 1'b0;
      ref_row  <= '0;
      overrun  <= 1'b0;
    end else begin
      timer    <= wrap ? '0 : timer + 1'b1;
      ref_pend <= wrap | (ref_pend & ~take);
      if (wrap && ref_pend && !take) overrun <= 1'b1;
      if (state == REF && last) ref_row <= ref_row + 1'b1;
    end
  end
  assign bus.ref_overrun = overrun;
`else
  assign ref_pend        = 1'b0;
  assign ref_row         = '0;
  assign bus.ref_overrun = 1'b0;
`endif
endmodule

// File: tb/tb_dram_addr_mux_ctl.sv
// tb_dram_addr_mux_ctl: directed accesses with a read-data scoreboard; refresh scenarios when DRAM_REFRESH_EN is defined
module tb_dram_addr_mux_ctl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] q_m[$];
  logic [7:0] q_r[$];
  always #5 clk = ~clk;
  dram_addr_mux_ctl_if #(.ROW_W(7), .DATA_W(8)) m ();
  dram_addr_mux_ctl_if #(.ROW_W(7), .DATA_W(8)) r ();
  dram_addr_mux_ctl_if #(.ROW_W(7), .DATA_W(8)) o ();
  dram_addr_mux_ctl #(.REF_PERIOD(64)) u_m (.clk(clk), .rst(rst), .bus(m));
  dram_addr_mux_ctl #(.REF_PERIOD(8))  u_r (.clk(clk), .rst(rst), .bus(r));
  dram_addr_mux_ctl #(.REF_PERIOD(4))  u_o (.clk(clk), .rst(rst), .bus(o));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic wait_ack_m();
    int n = 0;
    while (m.ack !== 1'b1 && n < 30) begin tick(); n++; end
    chk("m_ack_timeout", m.ack, 1);
  endtask
  task automatic wait_ack_r();
    int n = 0;
    while (r.ack !== 1'b1 && n < 30) begin tick(); n++; end
    chk("r_ack_timeout", r.ack, 1);
  endtask
  // scoreboard monitors: every ack must match the oldest expected read data
  always @(negedge clk) begin
    if (m.ack === 1'b1) begin
      if (q_m.size() == 0) chk("m_ack_unexpected", m.ack, 0);
      else chk("m_rdata", m.rdata, q_m.pop_front());
    end
    if (r.ack === 1'b1) begin
      if (q_r.size() == 0) chk("r_ack_unexpected", r.ack, 0);
      else chk("r_rdata", r.rdata, q_r.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    m.req = 0; m.addr = '0; m.we = 0; m.dram_q = '0;
    r.req = 0; r.addr = '0; r.we = 0; r.dram_q = '0;
    o.req = 0; o.addr = '0; o.we = 0; o.dram_q = '0;
    tick();
    do_reset();
    chk("rst_busy", m.busy, 0);
    chk("rst_ras", m.ras_n, 1);
    chk("rst_cas", m.cas_n, 1);
    chk("rst_we_n", m.we_n, 1);
    chk("rst_ma", m.ma, 0);
    chk("rst_ack", m.ack, 0);
    chk("rst_rdata", m.rdata, 0);
    chk("rst_ovr", m.ref_overrun, 0);
    // read 14'h1A5B: row 7'h34, column 7'h5B
    m.req = 1; m.addr = 14'h1A5B; m.we = 0; m.dram_q = 8'hC3; q_m.push_back(8'hC3);
    tick(); chk("rd_c1_ma", m.ma, 7'h34); chk("rd_c1_ras", m.ras_n, 0); chk("rd_c1_cas", m.cas_n, 1);
    tick(); chk("rd_c2_ma", m.ma, 7'h5B); chk("rd_c2_we_n", m.we_n, 1); chk("rd_c2_cas", m.cas_n, 1);
    tick(); chk("rd_c3_cas", m.cas_n, 0);
    tick(); chk("rd_c4_cas", m.cas_n, 0); chk("rd_c4_ma", m.ma, 7'h5B);
    tick(); chk("rd_c5_ack", m.ack, 1); chk("rd_c5_ras", m.ras_n, 1); m.req = 0;
    tick(); chk("rd_c6_ack", m.ack, 0); chk("rd_c6_busy", m.busy, 1);
    tick(); chk("rd_c7_idle", m.busy, 0);
    // write, rdata must keep the last read value; req held for a back-to-back read
    m.req = 1; m.we = 1; m.dram_q = 8'h77; q_m.push_back(8'hC3);
    tick(); m.addr = 14'h3FFF;
    tick(); chk("wr_c2_ma", m.ma, 7'h5B); chk("wr_c2_we_n", m.we_n, 0);
    tick(); chk("wr_c3_we_n", m.we_n, 0); chk("wr_c3_cas", m.cas_n, 0);
    tick(); chk("wr_c4_we_n", m.we_n, 0);
    tick(); chk("wr_c5_ack", m.ack, 1);
    m.addr = 14'h0081; m.we = 0; m.dram_q = 8'h5A; q_m.push_back(8'h5A);
    tick(); chk("wr_c6_busy", m.busy, 1);
    tick(); chk("wr_c7_idle", m.busy, 0);
    tick(); chk("b2b_c8_ma", m.ma, 7'h01); chk("b2b_c8_ras", m.ras_n, 0);
    repeat (4) tick();
    chk("b2b_ack", m.ack, 1); m.req = 0;
    repeat (2) tick(); chk("b2b_idle", m.busy, 0);
    // reset in the second CAS cycle
    do_reset();
    m.req = 1; m.addr = 14'h2A55; m.we = 0; m.dram_q = 8'h99;
    repeat (4) tick();
    chk("mr_c4_cas", m.cas_n, 0);
    rst = 1; m.req = 0;
    tick(); rst = 0;
    chk("mr_ras", m.ras_n, 1); chk("mr_cas", m.cas_n, 1); chk("mr_we_n", m.we_n, 1);
    chk("mr_busy", m.busy, 0); chk("mr_ack", m.ack, 0); chk("mr_rdata", m.rdata, 0); chk("mr_ma", m.ma, 0);
    m.req = 1; q_m.push_back(8'h99);
    tick(); chk("mr2_row", m.ma, 7'h54);
    wait_ack_m(); m.req = 0;
    repeat (3) tick(); chk("mr2_idle", m.busy, 0);
`ifdef DRAM_REFRESH_EN
    // refresh beats a request arriving in the cycle ref_pend is first visible
    do_reset();
    repeat (8) tick();
    chk("pri_idle", r.busy, 0);
    r.req = 1; r.addr = 14'h1A5B; r.we = 0; r.dram_q = 8'h3C; q_r.push_back(8'h3C);
    tick(); chk("pri_ref_ma", r.ma, 0); chk("pri_ref_ras", r.ras_n, 0); chk("pri_ref_cas", r.cas_n, 1);
    repeat (2) tick(); chk("pri_ref3_ras", r.ras_n, 0); chk("pri_ref3_cas", r.cas_n, 1);
    tick(); chk("pri_rpre_ras", r.ras_n, 1); chk("pri_rpre_ack", r.ack, 0);
    tick(); chk("pri_rpre2_busy", r.busy, 1);
    tick(); chk("pri_idle2", r.busy, 0);
    tick(); chk("pri_row", r.ma, 7'h34);
    wait_ack_r(); r.req = 0;
    // refresh rows 0..127 then wrap to 0
    do_reset();
    for (int i = 0; i <= 128; i++) begin
      int n = 0;
      while (r.ras_n !== 1'b0 && n < 20) begin tick(); n++; end
      chk("wrap_ref_seen", r.ras_n, 0);
      chk("wrap_ma", r.ma, i % 128);
      chk("wrap_cas", r.cas_n, 1);
      n = 0;
      while (r.ras_n === 1'b0 && n < 20) begin tick(); n++; end
    end
    chk("wrap_ovr", r.ref_overrun, 0);
    // refresh period shorter than refresh+access: overrun must stick until reset
    do_reset();
    o.req = 1; o.addr = 14'h0123;
    repeat (60) tick(); chk("ovr_set", o.ref_overrun, 1);
    o.req = 0;
    repeat (10) tick(); chk("ovr_sticky", o.ref_overrun, 1);
    do_reset(); chk("ovr_cleared", o.ref_overrun, 0);
`else
    o.req = 1; o.addr = 14'h0123;
    repeat (80) tick();
    chk("norf_ovr_o", o.ref_overrun, 0);
    chk("norf_ovr_r", r.ref_overrun, 0);
    chk("norf_ras_r", r.ras_n, 1);
    chk("norf_busy_r", r.busy, 0);
    o.req = 0;
`endif
    tick();
    chk("queue_drained", q_m.size() + q_r.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
